// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch buffer: runs fetch ahead of decode into a small FIFO of
// {address, instruction} pairs, drained over valid/ready and flushed on redirect.
module inst_prefetch_buf #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter logic [DATA_W-1:0]    NOP_INST = 32'h0000_0013,
    localparam int unsigned         PTR_W    = $clog2(DEPTH),
    localparam int unsigned         CNT_W    = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   rom_addr_o,
    output logic                rom_en_o,
    input  logic [DATA_W-1:0]   rom_inst_i,
    input  logic                jump_en_i,
    input  logic [ADDR_W-1:0]   jump_addr_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [DATA_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_addr_o,
    output logic [CNT_W-1:0]    count_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_inst [DEPTH];

    logic              w_not_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [ADDR_W-1:0] w_jump_target;

    assign w_not_empty   = (r_count != '0);
    assign w_full        = (r_count == FULL_CNT);
    assign w_pop         = w_not_empty & ready_i & ~jump_en_i;
    // A full buffer can still fetch when the head leaves in the same cycle.
    assign w_push        = ~jump_en_i & (~w_full | w_pop);
    assign w_jump_target = jump_addr_i & ~ADDR_W'(3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (jump_en_i) begin
            r_fetch_pc <= w_jump_target;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem_addr[r_wr_ptr] <= r_fetch_pc;
            r_mem_inst[r_wr_ptr] <= rom_inst_i;
        end
    end

    assign rom_addr_o  = r_fetch_pc;
    assign rom_en_o    = w_push;
    assign valid_o     = w_not_empty;
    assign count_o     = r_count;
    assign inst_o      = w_not_empty ? r_mem_inst[r_rd_ptr] : NOP_INST;
    assign inst_addr_o = w_not_empty ? r_mem_addr[r_rd_ptr] : '0;

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Self-checking bench for inst_prefetch_buf: directed vector table, hand-written
// redirect/reset/wrap sequences, and a randomized run against a behavioural model.
module tb_inst_prefetch_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rom_addr;
    logic        rom_en;
    logic [31:0] rom_inst;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [2:0]  count;

    logic [31:0] w_rom_addr;
    logic        w_rom_en;
    logic [31:0] w_rom_inst;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_addr;
    logic [2:0]  w_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM[i] = i, word addressed.
    assign rom_inst   = rom_addr >> 2;
    assign w_rom_inst = w_rom_addr >> 2;

    inst_prefetch_buf dut (
        .clk(clk), .rst(rst),
        .rom_addr_o(rom_addr), .rom_en_o(rom_en), .rom_inst_i(rom_inst),
        .jump_en_i(jump_en), .jump_addr_i(jump_addr),
        .valid_o(valid), .ready_i(ready),
        .inst_o(inst), .inst_addr_o(inst_addr), .count_o(count)
    );

    inst_prefetch_buf #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst),
        .rom_addr_o(w_rom_addr), .rom_en_o(w_rom_en), .rom_inst_i(w_rom_inst),
        .jump_en_i(1'b0), .jump_addr_i(32'h0),
        .valid_o(w_valid), .ready_i(1'b1),
        .inst_o(w_inst), .inst_addr_o(w_inst_addr), .count_o(w_count)
    );

    typedef struct {
        logic        ready;
        logic        jump;
        logic [31:0] jaddr;
        logic        ev;
        logic [31:0] ea;
        logic [2:0]  ec;
        logic [31:0] era;
        logic        een;
    } vec_t;

    vec_t tv[20];

    function automatic vec_t mk(logic rd, logic jp, logic [31:0] ja, logic ev,
                                logic [31:0] ea, logic [2:0] ec, logic [31:0] era,
                                logic een);
        vec_t v;
        v.ready = rd; v.jump = jp; v.jaddr = ja; v.ev = ev;
        v.ea = ea; v.ec = ec; v.era = era; v.een = een;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Leaves the bench at a falling edge with rst just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    logic [31:0] exp_inst;
    int          mcount;
    logic [31:0] mpc;
    logic [31:0] exp_next;
    logic        mpop;
    logic        mpush;
    int          pops;

    initial begin
        tv[0] = mk(0, 0, 0, 0, 32'h0, 3'd0, 32'h0,  1);
        tv[1] = mk(0, 0, 0, 1, 32'h0, 3'd1, 32'h4,  1);
        tv[2] = mk(0, 0, 0, 1, 32'h0, 3'd2, 32'h8,  1);
        tv[3] = mk(0, 0, 0, 1, 32'h0, 3'd3, 32'hC,  1);
        for (int i = 4; i < 10; i++)
            tv[i] = mk(0, 0, 0, 1, 32'h0, 3'd4, 32'h10, 0);
        for (int i = 10; i < 16; i++)
            tv[i] = mk(1, 0, 0, 1, 32'((i - 10) * 4), 3'd4, 32'(16 + (i - 10) * 4), 1);
        tv[16] = mk(1, 1, 32'h103, 1, 32'h18,  3'd4, 32'h28,  0);
        tv[17] = mk(1, 0, 0,       0, 32'h0,   3'd0, 32'h100, 1);
        tv[18] = mk(1, 0, 0,       1, 32'h100, 3'd1, 32'h104, 1);
        tv[19] = mk(1, 0, 0,       1, 32'h104, 3'd1, 32'h108, 1);

        // Directed table: fill, stall at full, drain, redirect while full.
        do_reset();
        chk("wrap_rom_addr_reset", w_rom_addr, 32'hFFFF_FFF8);
        for (int i = 0; i < 20; i++) begin
            ready = tv[i].ready; jump_en = tv[i].jump; jump_addr = tv[i].jaddr;
            #1;
            exp_inst = tv[i].ev ? (tv[i].ea >> 2) : 32'h13;
            chk($sformatf("v%0d_valid", i),     32'(valid),  32'(tv[i].ev));
            chk($sformatf("v%0d_inst_addr", i), inst_addr,   tv[i].ea);
            chk($sformatf("v%0d_inst", i),      inst,        exp_inst);
            chk($sformatf("v%0d_count", i),     32'(count),  32'(tv[i].ec));
            chk($sformatf("v%0d_rom_addr", i),  rom_addr,    tv[i].era);
            chk($sformatf("v%0d_rom_en", i),    32'(rom_en), 32'(tv[i].een));
            if (i == 1) chk("wrap_addr0", w_inst_addr, 32'hFFFF_FFF8);
            if (i == 2) chk("wrap_addr1", w_inst_addr, 32'hFFFF_FFFC);
            if (i == 3) chk("wrap_addr2", w_inst_addr, 32'h0000_0000);
            if (i == 3) chk("wrap_inst2", w_inst, 32'h0000_0000);
            @(negedge clk);
        end
        jump_en = 1'b0;

        // Redirect with 3 buffered entries and ready high: head must not pop.
        do_reset();
        repeat (3) @(negedge clk);
        ready = 1'b1; jump_en = 1'b1; jump_addr = 32'h103;
        #1;
        chk("j3_count_before", 32'(count),  32'd3);
        chk("j3_rom_en",       32'(rom_en), 32'd0);
        @(negedge clk);
        jump_en = 1'b0;
        #1;
        chk("j3_count_after",  32'(count), 32'd0);
        chk("j3_valid_after",  32'(valid), 32'd0);
        chk("j3_rom_addr",     rom_addr,   32'h100);
        @(negedge clk);
        #1;
        chk("j3_head_valid",   32'(valid), 32'd1);
        chk("j3_head_addr",    inst_addr,  32'h100);
        chk("j3_head_inst",    inst,       32'h40);

        // Reset pulse while full with ready toggling.
        @(negedge clk);
        ready = 1'b0;
        repeat (6) @(negedge clk);
        #1 chk("mr_full", 32'(count), 32'd4);
        @(negedge clk);
        rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        rst = 1'b1; ready = 1'b0;
        #1;
        chk("mr_valid",     32'(valid), 32'd0);
        chk("mr_inst",      inst,       32'h13);
        chk("mr_inst_addr", inst_addr,  32'h0);
        chk("mr_count",     32'(count), 32'd0);
        chk("mr_rom_addr",  rom_addr,   32'h0);
        @(negedge clk);
        ready = 1'b1;
        #1;
        chk("mr_refetch_valid", 32'(valid), 32'd1);
        chk("mr_refetch_addr",  inst_addr,  32'h0);
        @(negedge clk);
        #1 chk("mr_refetch_next", inst_addr, 32'h4);

        // Randomized run against a stream-level model.
        do_reset();
        mcount = 0; mpc = 32'h0; exp_next = 32'h0; pops = 0;
        for (int c = 0; c < 10000; c++) begin
            ready   = ($urandom_range(0, 9) < 7);
            jump_en = ($urandom_range(0, 19) == 0);
            jump_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                    : $urandom;
            #1;
            mpop  = (mcount > 0) && ready && !jump_en;
            mpush = !jump_en && ((mcount < DEPTH) || mpop);
            if (count > 3'(DEPTH))
                chk("rnd_count_bound", 32'(count), 32'(DEPTH));
            if (count == 3'(DEPTH) && !mpop && rom_en)
                chk("rnd_push_when_full", 32'(rom_en), 32'd0);
            if (count !== 3'(mcount)) chk($sformatf("rnd%0d_count", c), 32'(count), 32'(mcount));
            if (valid !== (mcount != 0)) chk($sformatf("rnd%0d_valid", c), 32'(valid), 32'(mcount != 0));
            if (rom_addr !== mpc) chk($sformatf("rnd%0d_rom_addr", c), rom_addr, mpc);
            if (rom_en !== mpush) chk($sformatf("rnd%0d_rom_en", c), 32'(rom_en), 32'(mpush));
            if (mpop) begin
                chk($sformatf("rnd%0d_accept_addr", c), inst_addr, exp_next);
                chk($sformatf("rnd%0d_accept_inst", c), inst, exp_next >> 2);
                pops++;
            end else if (mcount == 0) begin
                if (inst !== 32'h13) chk($sformatf("rnd%0d_empty_inst", c), inst, 32'h13);
                if (inst_addr !== 32'h0) chk($sformatf("rnd%0d_empty_addr", c), inst_addr, 32'h0);
            end
            if (jump_en) begin
                mcount   = 0;
                mpc      = jump_addr & ~32'h3;
                exp_next = mpc;
            end else begin
                if (mpop)  exp_next = exp_next + 32'd4;
                if (mpush) mpc = mpc + 32'd4;
                mcount = mcount + int'(mpush) - int'(mpop);
            end
            @(negedge clk);
        end
        if (pops < 1000) chk("rnd_accept_volume", 32'(pops), 32'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_buf.md
# inst_prefetch_buf

Parametrised instruction-fetch front end for the RV core; it replaces the single-pc fetch path (pc register feeding a pass-through fetch stage) between the instruction ROM and the IF/ID register. It runs ahead of decode, holding up to DEPTH fetched {address, instruction} pairs in a FIFO. It hands them to decode over a valid/ready handshake and discards all buffered work on a redirect (jump/branch) from execute.

## Interface
- ADDR_W, 32, width of instruction addresses.
- DATA_W, 32, width of instruction words.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- NOP_INST, 32'h0000_0013, value driven on inst_o when valid_o = 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low; sampled on rising edge of clk.
- rom_addr_o  out  ADDR_W  fetch address to instruction ROM.
- rom_en_o  out  1  fetch request this cycle.
- rom_inst_i  in  DATA_W  ROM read data, combinational, same cycle as rom_addr_o.
- jump_en_i  in  1  redirect request from execute.
- jump_addr_i  in  ADDR_W  redirect target; bits [1:0] ignored (treated as 0).
- valid_o  out  1  FIFO head holds a valid instruction.
- ready_i  in  1  decode accepts the head this cycle.
- inst_o  out  DATA_W  head instruction; NOP_INST when valid_o = 0.
- inst_addr_o  out  ADDR_W  head instruction address; 0 when valid_o = 0.
- count_o  out  log2(DEPTH)+1  number of buffered entries, 0..DEPTH.

## Operation
- State:
  - fetch_pc register.
  - DEPTH-entry FIFO of {addr, inst}.
  - Read pointer and write pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- pop = valid_o & ready_i & ~jump_en_i.
- push = rom_en_o, with rom_en_o = ~jump_en_i & (count < DEPTH | pop).
  - A full FIFO accepts a push in the same cycle as a pop.
- rom_addr_o = fetch_pc, always driven.
- On push:
  - Write {fetch_pc, rom_inst_i} at the write pointer and advance the write pointer.
  - fetch_pc ← fetch_pc + 4, modulo 2^ADDR_W; wrap from all-ones−3 to 0 is legal.
- On pop: advance the read pointer.
- count ← count + push − pop. Push and pop in the same cycle leave count unchanged.
- Redirect (jump_en_i = 1) has priority over push and pop:
  - Both pointers cleared, count ← 0.
  - fetch_pc ← {jump_addr_i[ADDR_W-1:2], 2'b00}.
  - No push and no pop that cycle. The head presented that cycle is not consumed, even if ready_i = 1.
- Outputs:
  - valid_o = (count ≠ 0).
  - inst_o and inst_addr_o come from the head entry, or NOP_INST and 0 when empty.
  - All outputs are decoded from registers; there is no combinational path from ready_i or jump_en_i to valid_o, inst_o or inst_addr_o.
- Reset (rst = 0 at an edge):
  - fetch_pc ← RESET_PC, pointers ← 0, count ← 0.
  - Outputs after that edge: valid_o = 0, inst_o = NOP_INST, inst_addr_o = 0, count_o = 0, rom_addr_o = RESET_PC.
  - rom_en_o follows its equation (1 while rst = 0, since count = 0). Pushes during reset are discarded because reset overrides all updates.
  - Reset asserted mid-stream drops all buffered entries. It overrides a simultaneous jump_en_i.

## Timing
- Fetch-to-decode latency is 1 cycle. An instruction fetched in cycle T is on inst_o with valid_o = 1 in cycle T+1.
- Redirect latency is 2 cycles:
  - jump_en_i in cycle T.
  - rom_addr_o = target in T+1.
  - Target instruction valid at the head in T+2.
  - valid_o = 0 in T+1.
- Steady state with ready_i held high: one instruction per cycle; count_o stays at 1.
- With ready_i low: count_o rises by 1 per cycle until it reaches DEPTH, then rom_en_o = 0 and fetch_pc holds.
- First ready_i = 1 cycle after full: pop and push occur together, and count_o stays at DEPTH.
- Back-to-back redirects: each one restarts the 2-cycle latency from the last redirect.

## Test plan
- Reset release with RESET_PC = 0, ROM[i] = i, ready_i = 1:
  - Required: inst_addr_o = 0, 4, 8, … on consecutive cycles starting 1 cycle after release.
  - Required: inst_o matches ROM; count_o = 1 throughout.
- ready_i = 0 for 10 cycles, DEPTH = 4:
  - Required: count_o goes 1, 2, 3, 4 and holds; rom_en_o = 0 once full; rom_addr_o frozen at 0x10.
  - Then ready_i = 1: required addresses 0, 4, 8, C, 10, 14 with no gap.
- FIFO holding 3 entries, jump_en_i with jump_addr_i = 0x103 and ready_i = 1 in the same cycle:
  - Required: no pop; next cycle count_o = 0 and rom_addr_o = 0x100.
  - Required: the following cycle inst_addr_o = 0x100 with valid_o = 1.
- Address wrap, RESET_PC = 0xFFFF_FFF8, ready_i = 1:
  - Required: inst_addr_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst = 0 for one cycle while full and ready_i toggling:
  - Required: next cycle valid_o = 0, inst_o = 0x13, count_o = 0.
  - Required: refetch starts at RESET_PC.
- Random ready_i and jump_en_i over 10k cycles:
  - Scoreboard checks the accepted instruction stream equals the ROM sequence restarted at each redirect target.
  - Assertions: count_o ≤ DEPTH; no push when full without a pop.
